// File: rtl/nand_bist_ctrl_pkg.sv
// Shared encodings and widths for the NAND gate BIST controller.
package nand_bist_ctrl_pkg;
   localparam int VEC_W = 2;
   localparam int CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_t;
endpackage

// File: rtl/nand_bist_ctrl_if.sv
// Control/status bundle between a BIST requester and the NAND BIST controller.
interface nand_bist_ctrl_if;
   import nand_bist_ctrl_pkg::*;

   logic             start;
   logic             abort;
   logic             fault_inj;
   logic             busy;
   logic             done;
   logic             pass;
   logic [CNT_W-1:0] err_cnt;
   logic [VEC_W-1:0] first_fail;
   logic             gate_a;
   logic             gate_b;

   modport master (output start, abort, fault_inj,
                   input  busy, done, pass, err_cnt, first_fail, gate_a, gate_b);
   modport slave  (input  start, abort, fault_inj,
                   output busy, done, pass, err_cnt, first_fail, gate_a, gate_b);
endinterface

// File: rtl/nand_gate.sv
// Two-input NAND gate under test.
module nand_gate (
   input  logic A,
   input  logic B,
   output logic Y
);
   assign Y = ~(A & B);
endmodule

// File: rtl/nand_bist_ctrl.sv
// Exhaustive 4-vector BIST of a NAND gate: apply, settle, compare, repeat for ITER sweeps.
module nand_bist_ctrl
   import nand_bist_ctrl_pkg::*;
#(
   parameter int SETTLE = 2,
   parameter int ITER   = 1
) (
   input logic             clk,
   input logic             rst_n,
   nand_bist_ctrl_if.slave bus
);
   state_t           state;
   logic [VEC_W-1:0] vec;
   logic [7:0]       sweep;
   logic [3:0]       wcnt;
   logic             y;
   logic             mismatch;

   nand_gate u_nand (.A(bus.gate_a), .B(bus.gate_b), .Y(y));

   // fault_inj flips the observed output so the compare path itself can be exercised.
   assign mismatch = (y ^ bus.fault_inj) != ~(bus.gate_a & bus.gate_b);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         vec            <= '0;
         sweep          <= '0;
         wcnt           <= '0;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
         bus.pass       <= 1'b0;
         bus.err_cnt    <= '0;
         bus.first_fail <= '0;
         bus.gate_a     <= 1'b0;
         bus.gate_b     <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start && !bus.abort) begin
                  state                     <= WAIT;
                  vec                       <= '0;
                  sweep                     <= '0;
                  wcnt                      <= '0;
                  bus.busy                  <= 1'b1;
                  bus.pass                  <= 1'b0;
                  bus.err_cnt               <= '0;
                  bus.first_fail            <= '0;
                  {bus.gate_a, bus.gate_b}  <= '0;
               end
            end
            WAIT: begin
               if (bus.abort) begin
                  state                    <= IDLE;
                  bus.busy                 <= 1'b0;
                  bus.pass                 <= 1'b0;
                  {bus.gate_a, bus.gate_b} <= '0;
               end else if (wcnt == 4'(SETTLE - 1)) begin
                  state <= CHECK;
                  wcnt  <= '0;
               end else begin
                  wcnt <= wcnt + 4'd1;
               end
            end
            CHECK: begin
               // An abort in the compare cycle wins: the result of this compare is dropped.
               if (bus.abort) begin
                  state                    <= IDLE;
                  bus.busy                 <= 1'b0;
                  bus.pass                 <= 1'b0;
                  {bus.gate_a, bus.gate_b} <= '0;
               end else begin
                  if (mismatch) begin
                     if (bus.err_cnt != {CNT_W{1'b1}})
                        bus.err_cnt <= bus.err_cnt + 1'b1;
                     if (bus.err_cnt == '0)
                        bus.first_fail <= {bus.gate_a, bus.gate_b};
                  end
                  if (vec != 2'd3) begin
                     state                    <= WAIT;
                     vec                      <= vec + 2'd1;
                     {bus.gate_a, bus.gate_b} <= vec + 2'd1;
                  end else if (sweep != 8'(ITER - 1)) begin
                     state                    <= WAIT;
                     vec                      <= '0;
                     sweep                    <= sweep + 8'd1;
                     {bus.gate_a, bus.gate_b} <= '0;
                  end else begin
                     state                    <= DONE;
                     bus.busy                 <= 1'b0;
                     bus.done                 <= 1'b1;
                     bus.pass                 <= (bus.err_cnt == '0) && !mismatch;
                     {bus.gate_a, bus.gate_b} <= '0;
                  end
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_nand_bist_ctrl.sv
// Randomized self-checking bench for nand_bist_ctrl against a cycle-schedule reference model.
module tb_nand_bist_ctrl;
   import nand_bist_ctrl_pkg::*;

   localparam int S    = 2;
   localparam int IT70 = 70;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   nand_bist_ctrl_if bus ();
   nand_bist_ctrl_if bus70 ();

   nand_bist_ctrl #(.SETTLE(S), .ITER(1))    dut   (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
   nand_bist_ctrl #(.SETTLE(S), .ITER(IT70)) dut70 (.clk(clk), .rst_n(rst_n), .bus(bus70.slave));

   int         n_cmp = 0;
   int         n_bad = 0;
   int         done_at;
   int         done_cnt;
   bit         fault_arr [0:63];
   logic [1:0] gate_tr   [0:63];
   logic       busy_tr   [0:63];

   // Vector driven in cycle T+j of a one-sweep run: each vector occupies SETTLE+1 cycles.
   function automatic logic [1:0] exp_gate(input int j);
      return 2'(((j - 1) / (S + 1)) % 4);
   endfunction

   // Compares happen in the last cycle of each vector slot; those at/after an abort are lost.
   function automatic int exp_err(input int abort_at);
      int e = 0;
      for (int k = 0; k < 4; k++) begin
         int c = (k + 1) * (S + 1);
         if ((abort_at == 0 || c < abort_at) && fault_arr[c]) e++;
      end
      return (e > 255) ? 255 : e;
   endfunction

   function automatic logic [1:0] exp_ff(input int abort_at);
      for (int k = 0; k < 4; k++) begin
         int c = (k + 1) * (S + 1);
         if ((abort_at == 0 || c < abort_at) && fault_arr[c]) return 2'(k);
      end
      return 2'd0;
   endfunction

   // Caller is at a negedge; start is sampled on the next posedge (cycle T ends there).
   task automatic run1(input int fmode, input int abort_at, input int start2_at, input int ncyc);
      for (int j = 0; j < 64; j++) fault_arr[j] = 1'b0;
      bus.start = 1'b1; bus.abort = 1'b0; bus.fault_inj = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      done_at = -1; done_cnt = 0;
      for (int j = 1; j <= ncyc; j++) begin
         gate_tr[j] = {bus.gate_a, bus.gate_b};
         busy_tr[j] = bus.busy;
         if (bus.done === 1'b1) begin
            done_cnt++;
            if (done_at < 0) done_at = j;
         end
         fault_arr[j]  = (fmode == 1) ? 1'b1 : (fmode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
         bus.fault_inj = fault_arr[j];
         bus.start     = (j == start2_at);
         bus.abort     = (j == abort_at);
         @(negedge clk);
      end
      bus.start = 1'b0; bus.abort = 1'b0; bus.fault_inj = 1'b0;
   endtask

   task automatic test_reset();
      bus.start = 1'b1; bus.abort = 1'b0; bus.fault_inj = 1'b0;
      bus70.start = 1'b0; bus70.abort = 1'b0; bus70.fault_inj = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({bus.busy, bus.done, bus.pass, bus.err_cnt, bus.first_fail, bus.gate_a, bus.gate_b} !== 15'd0) begin
         n_bad++; $display("FAIL reset_outputs: got %b want 0",
            {bus.busy, bus.done, bus.pass, bus.err_cnt, bus.first_fail, bus.gate_a, bus.gate_b});
      end
      n_cmp++;
      if ({bus70.busy, bus70.done, bus70.pass, bus70.err_cnt} !== 11'd0) begin
         n_bad++; $display("FAIL reset_outputs70: got %b want 0", {bus70.busy, bus70.done, bus70.pass, bus70.err_cnt});
      end
      bus.start = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_clean();
      run1(0, 0, 0, 16);
      n_cmp++; if (done_at !== 13) begin n_bad++; $display("FAIL clean_done_at: got %0d want 13", done_at); end
      n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL clean_done_cnt: got %0d want 1", done_cnt); end
      n_cmp++; if (bus.pass !== 1'b1) begin n_bad++; $display("FAIL clean_pass: got %b want 1", bus.pass); end
      n_cmp++; if (bus.err_cnt !== 8'd0) begin n_bad++; $display("FAIL clean_err: got %0d want 0", bus.err_cnt); end
      for (int j = 1; j <= 12; j++) begin
         n_cmp++;
         if (gate_tr[j] !== exp_gate(j)) begin
            n_bad++; $display("FAIL clean_gate[%0d]: got %b want %b", j, gate_tr[j], exp_gate(j));
         end
         n_cmp++;
         if (busy_tr[j] !== 1'b1) begin n_bad++; $display("FAIL clean_busy[%0d]: got %b want 1", j, busy_tr[j]); end
      end
      n_cmp++; if (busy_tr[13] !== 1'b0) begin n_bad++; $display("FAIL clean_busy_done: got %b want 0", busy_tr[13]); end
   endtask

   task automatic test_fault();
      run1(1, 0, 0, 16);
      n_cmp++; if (bus.err_cnt !== 8'd4) begin n_bad++; $display("FAIL fault_err: got %0d want 4", bus.err_cnt); end
      n_cmp++; if (bus.first_fail !== 2'b00) begin n_bad++; $display("FAIL fault_ff: got %b want 00", bus.first_fail); end
      n_cmp++; if (bus.pass !== 1'b0) begin n_bad++; $display("FAIL fault_pass: got %b want 0", bus.pass); end
      n_cmp++; if (done_at !== 13) begin n_bad++; $display("FAIL fault_done_at: got %0d want 13", done_at); end
   endtask

   task automatic test_random();
      for (int r = 0; r < 10; r++) begin
         int e;
         run1(2, 0, 0, 16);
         e = exp_err(0);
         n_cmp++; if (bus.err_cnt !== 8'(e)) begin n_bad++; $display("FAIL rand%0d_err: got %0d want %0d", r, bus.err_cnt, e); end
         n_cmp++; if (bus.first_fail !== exp_ff(0)) begin n_bad++; $display("FAIL rand%0d_ff: got %b want %b", r, bus.first_fail, exp_ff(0)); end
         n_cmp++; if (bus.pass !== (e == 0)) begin n_bad++; $display("FAIL rand%0d_pass: got %b want %b", r, bus.pass, e == 0); end
         n_cmp++; if (done_at !== 13) begin n_bad++; $display("FAIL rand%0d_done_at: got %0d want 13", r, done_at); end
      end
   endtask

   task automatic test_start_while_busy();
      run1(0, 0, 3, 16);
      n_cmp++; if (done_at !== 13) begin n_bad++; $display("FAIL busy_start_done_at: got %0d want 13", done_at); end
      n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL busy_start_done_cnt: got %0d want 1", done_cnt); end
      n_cmp++; if (busy_tr[14] !== 1'b0) begin n_bad++; $display("FAIL busy_start_requeue: got %b want 0", busy_tr[14]); end
   endtask

   task automatic test_abort();
      run1(0, 0, 0, 16);
      run1(1, 5, 0, 10);
      n_cmp++; if (busy_tr[5] !== 1'b1) begin n_bad++; $display("FAIL abort_busy_before: got %b want 1", busy_tr[5]); end
      n_cmp++; if (busy_tr[6] !== 1'b0) begin n_bad++; $display("FAIL abort_busy_after: got %b want 0", busy_tr[6]); end
      n_cmp++; if (done_cnt !== 0) begin n_bad++; $display("FAIL abort_done_cnt: got %0d want 0", done_cnt); end
      n_cmp++; if (bus.pass !== 1'b0) begin n_bad++; $display("FAIL abort_pass: got %b want 0", bus.pass); end
      n_cmp++; if (bus.err_cnt !== 8'(exp_err(5))) begin n_bad++; $display("FAIL abort_err: got %0d want %0d", bus.err_cnt, exp_err(5)); end
      run1(1, 6, 0, 10);
      n_cmp++; if (bus.err_cnt !== 8'(exp_err(6))) begin n_bad++; $display("FAIL abort_check_err: got %0d want %0d", bus.err_cnt, exp_err(6)); end
      n_cmp++; if (gate_tr[7] !== 2'b00) begin n_bad++; $display("FAIL abort_gate_idle: got %b want 00", gate_tr[7]); end
   endtask

   task automatic test_start_abort_idle();
      logic [7:0] held;
      held = 8'(exp_err(6));
      bus.start = 1'b1; bus.abort = 1'b1;
      @(negedge clk);
      bus.start = 1'b0; bus.abort = 1'b0;
      n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL both_busy: got %b want 0", bus.busy); end
      @(negedge clk);
      n_cmp++; if (bus.err_cnt !== held) begin n_bad++; $display("FAIL both_err_held: got %0d want %0d", bus.err_cnt, held); end
   endtask

   task automatic test_reset_mid_run();
      bus.fault_inj = 1'b1; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (6) @(negedge clk);
      n_cmp++; if (bus.err_cnt !== 8'd2) begin n_bad++; $display("FAIL midrst_err_before: got %0d want 2", bus.err_cnt); end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({bus.busy, bus.done, bus.pass, bus.err_cnt, bus.first_fail, bus.gate_a, bus.gate_b} !== 15'd0) begin
         n_bad++; $display("FAIL midrst_outputs: got %b want 0",
            {bus.busy, bus.done, bus.pass, bus.err_cnt, bus.first_fail, bus.gate_a, bus.gate_b});
      end
      @(negedge clk);
      rst_n = 1'b1; bus.fault_inj = 1'b0;
      run1(0, 0, 0, 16);
      n_cmp++; if (done_at !== 13) begin n_bad++; $display("FAIL midrst_done_at: got %0d want 13", done_at); end
      n_cmp++; if (bus.pass !== 1'b1) begin n_bad++; $display("FAIL midrst_pass: got %b want 1", bus.pass); end
   endtask

   task automatic test_back_to_back();
      run1(1, 0, 0, 13);
      n_cmp++; if (done_at !== 13) begin n_bad++; $display("FAIL b2b_first_done: got %0d want 13", done_at); end
      run1(0, 0, 0, 16);
      n_cmp++; if (done_at !== 13) begin n_bad++; $display("FAIL b2b_second_done: got %0d want 13", done_at); end
      n_cmp++; if (bus.err_cnt !== 8'd0) begin n_bad++; $display("FAIL b2b_err_cleared: got %0d want 0", bus.err_cnt); end
      n_cmp++; if (bus.pass !== 1'b1) begin n_bad++; $display("FAIL b2b_pass: got %b want 1", bus.pass); end
   endtask

   task automatic test_saturation();
      int exp_done, d_at, total;
      logic [7:0] mid;
      exp_done = 4 * IT70 * (S + 1) + 1;
      total    = (4 * IT70 > 255) ? 255 : 4 * IT70;
      d_at = -1; mid = '0;
      bus70.fault_inj = 1'b1; bus70.start = 1'b1;
      @(negedge clk);
      bus70.start = 1'b0;
      for (int j = 1; j <= 900 && d_at < 0; j++) begin
         if (j == 100 * (S + 1) + 1) mid = bus70.err_cnt;
         if (bus70.done === 1'b1) d_at = j;
         @(negedge clk);
      end
      bus70.fault_inj = 1'b0;
      n_cmp++; if (d_at !== exp_done) begin n_bad++; $display("FAIL sat_done_at: got %0d want %0d", d_at, exp_done); end
      n_cmp++; if (mid !== 8'd100) begin n_bad++; $display("FAIL sat_mid_err: got %0d want 100", mid); end
      n_cmp++; if (bus70.err_cnt !== 8'(total)) begin n_bad++; $display("FAIL sat_err: got %0d want %0d", bus70.err_cnt, total); end
      n_cmp++; if (bus70.pass !== 1'b0) begin n_bad++; $display("FAIL sat_pass: got %b want 0", bus70.pass); end
      n_cmp++; if (bus70.first_fail !== 2'b00) begin n_bad++; $display("FAIL sat_ff: got %b want 00", bus70.first_fail); end
   endtask

   initial begin
      test_reset();
      test_clean();
      test_fault();
      test_random();
      test_start_while_busy();
      test_abort();
      test_start_abort_idle();
      test_reset_mid_run();
      test_back_to_back();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
